lzc_normalizer: RTL and testbench



---
 rtl/lzc_pkg.sv | 36 +++
 rtl/norm_shifter.sv | 26 ++
 rtl/lzc_normalizer.sv | 139 +++++++++++++
 tb/tb_lzc_normalizer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// lzc_pkg: shared payload types, width helper and reset constants.
// LZC_NORM_EXP_EN adds an exponent lane to both stage payloads.
package lzc_pkg;

  function automatic int lzc_sw(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int LZC_WIDTH = 16;
  localparam int LZC_EXP_W = 8;
  localparam int LZC_SW    = lzc_sw(LZC_WIDTH);

  typedef struct packed {
    logic [LZC_WIDTH-1:0] data;
    logic [LZC_SW-1:0]    count;
    logic                 zero;
`ifdef LZC_NORM_EXP_EN
    logic [LZC_EXP_W-1:0] exp;
`endif
  } s1_pay_t;

  typedef struct packed {
    logic [LZC_WIDTH-1:0] data;
    logic [LZC_SW-1:0]    shamt;
    logic                 zero;
`ifdef LZC_NORM_EXP_EN
    logic [LZC_EXP_W-1:0] exp;
    logic                 uf;
`endif
  } s2_pay_t;

  localparam s1_pay_t S1_RST    = '0;
  localparam s2_pay_t S2_RST    = '0;
  localparam logic    VALID_RST = 1'b0;

endpackage

// File: rtl/norm_shifter.sv
// norm_shifter: log2(WIDTH)-level combinational left barrel shifter.
// Shift amounts of WIDTH or more are not representable; zero input covers that case.
module norm_shifter
  import lzc_pkg::*;
#(
  parameter  int WIDTH = LZC_WIDTH,
  localparam int LW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    shamt,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] lvl [0:LW];

  assign lvl[0] = in_data;

  for (genvar i = 0; i < LW; i++) begin : g_lvl
    assign lvl[i+1] = shamt[i]
                    ? (lvl[i] << (2 ** i))
                    : lvl[i];
  end

  assign out_data = lvl[LW];

endmodule

// File: rtl/lzc_normalizer.sv
// lzc_normalizer: 2-stage leading-zero count and normalize pipeline.
// Optional exponent adjust lane enabled by defining LZC_NORM_EXP_EN.
module lzc_normalizer
  import lzc_pkg::*;
#(
  parameter  int WIDTH = LZC_WIDTH,
  parameter  int EXP_W = LZC_EXP_W,
  localparam int SW    = lzc_sw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_shamt,
  output logic             out_zero
`ifdef LZC_NORM_EXP_EN
  ,
  input  logic [EXP_W-1:0] exp_in,
  output logic [EXP_W-1:0] exp_out,
  output logic             exp_uf
`endif
);

  localparam int LW = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lzc_normalizer: WIDTH must be a power of two >= 2");
  end

  // Stage payloads are sized by the package, so overrides must agree.
  if (WIDTH != LZC_WIDTH || EXP_W != LZC_EXP_W) begin : g_bad_pkg
    $error("lzc_normalizer: WIDTH/EXP_W must match lzc_pkg");
  end

  logic    s1_valid_q, s1_valid_d;
  logic    s2_valid_q, s2_valid_d;
  s1_pay_t s1_q, s1_d;
  s2_pay_t s2_q, s2_d;

  logic s2_ld;
  logic acc;
  logic s1_adv;

  assign s2_ld    = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_ld;
  assign acc      = in_valid & in_ready;
  assign s1_adv   = s1_valid_q & s2_ld;

  logic [SW-1:0] lz_cnt;
  logic          lz_zero;

  always_comb begin
    lz_cnt  = SW'(WIDTH);
    lz_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        lz_cnt  = SW'(WIDTH - 1 - i);
        lz_zero = 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] sh_data;

  norm_shifter #(
    .WIDTH(WIDTH)
  ) u_shift (
    .in_data (s1_q.data),
    .shamt   (s1_q.count[LW-1:0]),
    .out_data(sh_data)
  );

`ifdef LZC_NORM_EXP_EN
  localparam int XW = EXP_W + SW;

  logic [XW-1:0] x_exp;
  logic [XW-1:0] x_cnt;

  assign x_exp = XW'(s1_q.exp);
  assign x_cnt = XW'(s1_q.count);
`endif

  always_comb begin
    s1_valid_d = acc | (s1_valid_q & ~s2_ld);
    s1_d       = s1_q;
    if (acc) begin
      s1_d.data  = in_data;
      s1_d.count = lz_cnt;
      s1_d.zero  = lz_zero;
`ifdef LZC_NORM_EXP_EN
      s1_d.exp   = exp_in;
`endif
    end
  end

  always_comb begin
    s2_valid_d = s2_ld ? s1_valid_q : s2_valid_q;
    s2_d       = s2_q;
    if (s1_adv) begin
      s2_d.data  = sh_data;
      s2_d.shamt = s1_q.count;
      s2_d.zero  = s1_q.zero;
`ifdef LZC_NORM_EXP_EN
      s2_d.exp   = s1_q.zero
                 ? '0
                 : s1_q.exp - EXP_W'(s1_q.count);
      s2_d.uf    = ~s1_q.zero & (x_exp < x_cnt);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= VALID_RST;
      s2_valid_q <= VALID_RST;
      s1_q       <= S1_RST;
      s2_q       <= S2_RST;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_q.data;
  assign out_shamt = s2_q.shamt;
  assign out_zero  = s2_q.zero;
`ifdef LZC_NORM_EXP_EN
  assign exp_out   = s2_q.exp;
  assign exp_uf    = s2_q.uf;
`endif

endmodule

// File: tb/tb_lzc_normalizer.sv
// tb_lzc_normalizer: vector table, hand sequences and random scoreboard.
// Exponent checks are compiled in when LZC_NORM_EXP_EN is defined.
module tb_lzc_normalizer;

  localparam int W  = 16;
  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_shamt;
  logic        out_zero;
  logic [7:0]  exp_in;
`ifdef LZC_NORM_EXP_EN
  logic [7:0]  exp_out;
  logic        exp_uf;
`endif

  lzc_normalizer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_shamt(out_shamt),
    .out_zero (out_zero)
`ifdef LZC_NORM_EXP_EN
    ,
    .exp_in   (exp_in),
    .exp_out  (exp_out),
    .exp_uf   (exp_uf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [4:0]  shamt;
    logic        zero;
    logic [7:0]  eo;
    logic        uf;
  } res_t;

  // Normalize by repeated doubling until the top bit is set.
  function automatic res_t ref_norm(input logic [15:0] v,
                                    input logic [7:0] e);
    res_t r;
    int   s = 0;
    r.zero = (v == 16'h0);
    if (r.zero) s = W;
    else begin
      while (v[W-1] == 1'b0) begin
        v = v << 1;
        s++;
      end
    end
    r.data  = v;
    r.shamt = 5'(s);
    r.eo    = r.zero ? 8'h0 : 8'(int'(e) - s);
    r.uf    = !r.zero && (int'(e) < s);
    return r;
  endfunction

  typedef struct {
    logic [15:0] din;
    logic [15:0] wd;
    int          ws;
    logic        wz;
  } vec_t;

  vec_t vt [NV];

  res_t        q [$];
  bit          sb_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] held;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_spurious got=%0h want=none", out_data);
        end else begin
          res_t r;
          r = q.pop_front();
          chk("sb_data", 32'(out_data), 32'(r.data));
          chk("sb_shamt", 32'(out_shamt), 32'(r.shamt));
          chk("sb_zero", 32'(out_zero), 32'(r.zero));
`ifdef LZC_NORM_EXP_EN
          chk("sb_exp", 32'(exp_out), 32'(r.eo));
          chk("sb_uf", 32'(exp_uf), 32'(r.uf));
`endif
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (in_valid && in_ready)
        q.push_back(ref_norm(in_data, exp_in));
      chk("inflight", 32'(q.size() <= 2), 32'd1);
    end
  end

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> $urandom_range(0, 16);
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h0001, 16'h8000, 15, 1'b0};
    vt[1] = '{16'h8000, 16'h8000, 0,  1'b0};
    vt[2] = '{16'h0000, 16'h0000, 16, 1'b1};
    vt[3] = '{16'h0F00, 16'hF000, 4,  1'b0};
    vt[4] = '{16'h00F0, 16'hF000, 8,  1'b0};
    vt[5] = '{16'h000F, 16'hF000, 12, 1'b0};
    vt[6] = '{16'h0100, 16'h8000, 7,  1'b0};
    vt[7] = '{16'h1234, 16'h91A0, 3,  1'b0};
    vt[8] = '{16'h0003, 16'hC000, 14, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    exp_in    = 8'h0;
    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_shamt", 32'(out_shamt), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // back-to-back table stream
    out_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      in_valid = (i < NV);
      if (i < NV) in_data = vt[i].din;
      step();
      if (i >= 1) begin
        chk($sformatf("v%0d_valid", i-1), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_data", i-1), 32'(out_data), 32'(vt[i-1].wd));
        chk($sformatf("v%0d_shamt", i-1), 32'(out_shamt), 32'(vt[i-1].ws));
        chk($sformatf("v%0d_zero", i-1), 32'(out_zero), 32'(vt[i-1].wz));
      end
    end
    in_valid = 1'b0;
    step();
    chk("tbl_drain", 32'(out_valid), 32'd0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0F00;
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_data = 16'h00F0;
    step();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'hF000);
    chk("bp_shamt", 32'(out_shamt), 32'd4);
    in_data = 16'h000F;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'hF000);
      chk("bp_hold_shamt", 32'(out_shamt), 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_o2_shamt", 32'(out_shamt), 32'd8);
    chk("bp_o2_data", 32'(out_data), 32'hF000);
    step();
    chk("bp_o3_shamt", 32'(out_shamt), 32'd12);
    chk("bp_o3_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // reset with two operands in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    step();
    in_data = 16'h0003;
    step();
    in_valid = 1'b0;
    chk("mr_full", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_shamt", 32'(out_shamt), 32'd0);
    chk("mr_zero", 32'(out_zero), 32'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    step();
    in_valid = 1'b0;
    chk("mr_lat1", 32'(out_valid), 32'd0);
    step();
    chk("mr_valid2", 32'(out_valid), 32'd1);
    chk("mr_data2", 32'(out_data), 32'h8000);
    chk("mr_shamt2", 32'(out_shamt), 32'd7);
    step();

`ifdef LZC_NORM_EXP_EN
    in_valid = 1'b1;
    in_data  = 16'h0010;
    exp_in   = 8'd5;
    step();
    exp_in = 8'd20;
    step();
    chk("ex1_shamt", 32'(out_shamt), 32'd11);
    chk("ex1_exp", 32'(exp_out), 32'hFA);
    chk("ex1_uf", 32'(exp_uf), 32'd1);
    in_data = 16'h0000;
    exp_in  = 8'd3;
    step();
    in_valid = 1'b0;
    chk("ex2_exp", 32'(exp_out), 32'd9);
    chk("ex2_uf", 32'(exp_uf), 32'd0);
    step();
    chk("ex3_zero", 32'(out_zero), 32'd1);
    chk("ex3_exp", 32'(exp_out), 32'd0);
    chk("ex3_uf", 32'(exp_uf), 32'd0);
    step();
`endif

    // random traffic against the reference model
    sb_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rand_op();
      exp_in    = 8'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    sb_en = 1'b0;
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
